retire_trace_sync: RTL and testbench

//  Captures one record per instruction retired in the processor WB stage and buffers it in a FIFO.

---
 rtl/retire_trace_sync_if.sv | 45 ++++
 rtl/retire_trace_sync.sv | 99 +++++++++
 tb/tb_retire_trace_sync.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_sync_if.sv
// Retire trace bundle: WB-stage capture side plus checker-side
// valid/ready head record, with occupancy and overflow status.
interface retire_trace_sync_if #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wb_valid;
    logic [31:0]      wb_pc;
    logic             wb_store;
    logic [1:0]       wb_size;
    logic [31:0]      wb_addr;
    logic [31:0]      wb_data;
    logic             trace_full;
    logic [CW-1:0]    count;
    logic             check_en;
    logic             check_ready;
    logic [31:0]      check_pc;
    logic             check_store;
    logic [1:0]       check_size;
    logic [31:0]      check_addr;
    logic [31:0]      check_data;
    logic             check_misalign;
    logic [SEQ_W-1:0] check_seq;
    logic             overflow;

    modport master (
        output wb_valid, wb_pc, wb_store, wb_size,
        output wb_addr, wb_data, check_ready,
        input  trace_full, count, check_en, check_pc,
        input  check_store, check_size, check_addr,
        input  check_data, check_misalign, check_seq,
        input  overflow
    );

    modport slave (
        input  wb_valid, wb_pc, wb_store, wb_size,
        input  wb_addr, wb_data, check_ready,
        output trace_full, count, check_en, check_pc,
        output check_store, check_size, check_addr,
        output check_data, check_misalign, check_seq,
        output overflow
    );
endinterface

// File: rtl/retire_trace_sync.sv
// Retire trace FIFO: one record per WB retire, presented in order
// to the lock-step checker with back-pressure and sticky overflow.
module retire_trace_sync #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 flush,
    retire_trace_sync_if.slave  tr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [SEQ_W-1:0] seq;
    logic             ovf;
    logic             full;
    logic             nonempty;
    logic             push;
    logic             pop;
    logic             mis_in;

    logic [31:0]      m_pc   [DEPTH];
    logic             m_st   [DEPTH];
    logic [1:0]       m_sz   [DEPTH];
    logic [31:0]      m_addr [DEPTH];
    logic [31:0]      m_data [DEPTH];
    logic             m_mis  [DEPTH];
    logic [SEQ_W-1:0] m_seq  [DEPTH];

    assign full     = (cnt == CW'(DEPTH));
    assign nonempty = (cnt != '0);
    assign push     = tr.wb_valid && !full && !flush;
    assign pop      = nonempty && tr.check_ready && !flush;

    assign mis_in = tr.wb_store &&
                    ((tr.wb_size == 2'd1 && tr.wb_addr[0]) ||
                     (tr.wb_size == 2'd2 && tr.wb_addr[1:0] != 2'd0) ||
                     (tr.wb_size == 2'd3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            seq    <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            seq    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + SEQ_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            // a pop in the same cycle does not make room for this push
            if (tr.wb_valid && full)
                ovf <= 1'b1;
        end
    end

    // Payload storage needs no reset: outputs are gated by occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            m_pc[wr_ptr]   <= tr.wb_pc;
            m_st[wr_ptr]   <= tr.wb_store;
            m_sz[wr_ptr]   <= tr.wb_size;
            m_addr[wr_ptr] <= tr.wb_store ? tr.wb_addr : 32'd0;
            m_data[wr_ptr] <= tr.wb_store ? tr.wb_data : 32'd0;
            m_mis[wr_ptr]  <= mis_in;
            m_seq[wr_ptr]  <= seq;
        end
    end

    assign tr.trace_full     = full;
    assign tr.count          = cnt;
    assign tr.overflow       = ovf;
    assign tr.check_en       = nonempty;
    assign tr.check_pc       = nonempty ? m_pc[rd_ptr]   : 32'd0;
    assign tr.check_store    = nonempty ? m_st[rd_ptr]   : 1'b0;
    assign tr.check_size     = nonempty ? m_sz[rd_ptr]   : 2'd0;
    assign tr.check_addr     = nonempty ? m_addr[rd_ptr] : 32'd0;
    assign tr.check_data     = nonempty ? m_data[rd_ptr] : 32'd0;
    assign tr.check_misalign = nonempty ? m_mis[rd_ptr]  : 1'b0;
    assign tr.check_seq      = nonempty ? m_seq[rd_ptr]  : '0;
endmodule

// File: tb/tb_retire_trace_sync.sv
// Bench for retire_trace_sync: directed table, corner sequences
// and random traffic checked against a queue-based model.
module tb_retire_trace_sync;
    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;

    logic clk;
    logic rst;
    logic flush;

    retire_trace_sync_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) tr ();

    retire_trace_sync #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .tr    (tr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        st;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic        mis;
        logic [15:0] seq;
    } rec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        st;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
        logic        en;
        logic [31:0] epc;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        emis;
        logic [15:0] eseq;
        logic [3:0]  ecnt;
    } vec_t;

    rec_t q[$];
    int   seq_m;
    logic ovf_m;
    int   nchk;
    int   nerr;
    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic st, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input logic fl);
        tr.wb_valid    = v;
        tr.wb_pc       = pc;
        tr.wb_store    = st;
        tr.wb_size     = sz;
        tr.wb_addr     = a;
        tr.wb_data     = d;
        tr.check_ready = rdy;
        flush          = fl;
    endtask

    task automatic model_reset();
        q.delete();
        seq_m = 0;
        ovf_m = 1'b0;
    endtask

    function automatic rec_t mk();
        rec_t r;
        int   bytes;
        bytes = 1 << tr.wb_size;
        r.pc  = tr.wb_pc;
        r.st  = tr.wb_store;
        r.sz  = tr.wb_size;
        r.a   = tr.wb_store ? tr.wb_addr : 32'd0;
        r.d   = tr.wb_store ? tr.wb_data : 32'd0;
        r.mis = tr.wb_store &&
                (tr.wb_size == 2'd3 || (tr.wb_addr % bytes) != 0);
        r.seq = 16'(seq_m);
        return r;
    endfunction

    task automatic model_update();
        rec_t r;
        bit   do_pop;
        bit   do_push;
        if (flush) begin
            model_reset();
        end else begin
            do_pop  = q.size() > 0 && tr.check_ready;
            do_push = tr.wb_valid && q.size() < DEPTH;
            if (tr.wb_valid && q.size() == DEPTH) ovf_m = 1'b1;
            if (do_pop) r = q.pop_front();
            if (do_push) begin
                q.push_back(mk());
                seq_m = (seq_m + 1) % 65536;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        rec_t h;
        h = '{default: '0};
        if (q.size() > 0) h = q[0];
        chk({tag, ".en"},    64'(tr.check_en), 64'(q.size() > 0));
        chk({tag, ".count"}, 64'(tr.count), 64'(q.size()));
        chk({tag, ".full"},  64'(tr.trace_full), 64'(q.size() == DEPTH));
        chk({tag, ".ovf"},   64'(tr.overflow), 64'(ovf_m));
        chk({tag, ".pc"},    64'(tr.check_pc), 64'(h.pc));
        chk({tag, ".st"},    64'(tr.check_store), 64'(h.st));
        chk({tag, ".sz"},    64'(tr.check_size), 64'(h.sz));
        chk({tag, ".addr"},  64'(tr.check_addr), 64'(h.a));
        chk({tag, ".data"},  64'(tr.check_data), 64'(h.d));
        chk({tag, ".mis"},   64'(tr.check_misalign), 64'(h.mis));
        chk({tag, ".seq"},   64'(tr.check_seq), 64'(h.seq));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] prev;
        bit          wrapped;
        nchk = 0;
        nerr = 0;

        vt[0] = '{1'b1, 32'h00400000, 1'b0, 2'd0, 32'h1234, 32'h5678, 1'b0,
                  1'b1, 32'h00400000, 32'h0, 32'h0, 1'b0, 16'd0, 4'd1};
        vt[1] = '{1'b1, 32'h00400004, 1'b1, 2'd2, 32'h10000004, 32'hDEADBEEF,
                  1'b1, 1'b1, 32'h00400004, 32'h10000004, 32'hDEADBEEF,
                  1'b0, 16'd1, 4'd1};
        vt[2] = '{1'b1, 32'h00400008, 1'b1, 2'd1, 32'h10000001, 32'h0000BEEF,
                  1'b1, 1'b1, 32'h00400008, 32'h10000001, 32'h0000BEEF,
                  1'b1, 16'd2, 4'd1};
        vt[3] = '{1'b1, 32'h0040000C, 1'b1, 2'd0, 32'h10000003, 32'h000000AB,
                  1'b1, 1'b1, 32'h0040000C, 32'h10000003, 32'h000000AB,
                  1'b0, 16'd3, 4'd1};
        vt[4] = '{1'b1, 32'h00400010, 1'b1, 2'd3, 32'h10000000, 32'h1,
                  1'b1, 1'b1, 32'h00400010, 32'h10000000, 32'h1,
                  1'b1, 16'd4, 4'd1};
        vt[5] = '{1'b1, 32'h00400014, 1'b1, 2'd2, 32'h10000002, 32'h2,
                  1'b1, 1'b1, 32'h00400014, 32'h10000002, 32'h2,
                  1'b1, 16'd5, 4'd1};
        vt[6] = '{1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1,
                  1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 4'd0};
        vt[7] = '{1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0,
                  1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 4'd0};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].v, vt[i].pc, vt[i].st, vt[i].sz,
                  vt[i].a, vt[i].d, vt[i].rdy, 1'b0);
            step($sformatf("vec%0d", i));
            chk($sformatf("tab%0d.en", i), 64'(tr.check_en), 64'(vt[i].en));
            chk($sformatf("tab%0d.pc", i), 64'(tr.check_pc), 64'(vt[i].epc));
            chk($sformatf("tab%0d.addr", i), 64'(tr.check_addr), 64'(vt[i].ea));
            chk($sformatf("tab%0d.data", i), 64'(tr.check_data), 64'(vt[i].ed));
            chk($sformatf("tab%0d.mis", i), 64'(tr.check_misalign),
                64'(vt[i].emis));
            chk($sformatf("tab%0d.seq", i), 64'(tr.check_seq), 64'(vt[i].eseq));
            chk($sformatf("tab%0d.cnt", i), 64'(tr.count), 64'(vt[i].ecnt));
        end

        // fill, overflow, ordered drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00500000 + 32'(i * 4), 1'b0, 2'd0, 32'd0, 32'd0,
                  1'b0, 1'b0);
            step("fill");
        end
        chk("fill.full", 64'(tr.trace_full), 64'd1);
        chk("fill.count", 64'(tr.count), 64'd8);
        drive(1'b1, 32'hBAD00000, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("drop");
        chk("drop.ovf", 64'(tr.overflow), 64'd1);
        chk("drop.count", 64'(tr.count), 64'd8);
        drive(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d.seq", i), 64'(tr.check_seq), 64'(i));
            chk($sformatf("drain%0d.pc", i), 64'(tr.check_pc),
                64'(32'h00500000 + 32'(i * 4)));
            step("drain");
        end
        chk("drain.en", 64'(tr.check_en), 64'd0);

        // push+pop while full: push is still dropped
        drive(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step("flush1");
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00600000 + 32'(i), 1'b1, 2'd2,
                  32'h20000000 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
            step("fill2");
        end
        drive(1'b1, 32'hBAD00004, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step("fullpp");
        chk("fullpp.count", 64'(tr.count), 64'd7);
        chk("fullpp.ovf", 64'(tr.overflow), 64'd1);

        // steady streaming across the sequence wrap
        drive(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step("flush2");
        drive(1'b1, 32'h00700000, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("prime");
        wrapped = 1'b0;
        prev    = tr.check_seq;
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, 32'h00700000 + 32'(i * 4), 1'b0, 2'd0, 32'd0, 32'd0,
                  1'b1, 1'b0);
            step("stream");
            if (prev == 16'hFFFF && tr.check_seq == 16'h0000) wrapped = 1'b1;
            prev = tr.check_seq;
        end
        chk("stream.wrap", 64'(wrapped), 64'd1);
        chk("stream.count", 64'(tr.count), 64'd1);
        chk("stream.ovf", 64'(tr.overflow), 64'd0);

        // async reset mid-burst
        drive(1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step("flush3");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h00800000 + 32'(i * 4), 1'b1, 2'd1,
                  32'h30000001, 32'hFF, 1'b0, 1'b0);
            step("burst");
        end
        chk("burst.count", 64'(tr.count), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_model("arst");
        chk("arst.en", 64'(tr.check_en), 64'd0);
        chk("arst.count", 64'(tr.count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // flush with count=3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00900000 + 32'(i * 4), 1'b0, 2'd0, 32'd0, 32'd0,
                  1'b0, 1'b0);
            step("pre");
        end
        chk("pre.count", 64'(tr.count), 64'd3);
        drive(1'b1, 32'h00900100, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        step("flush4");
        chk("flush.count", 64'(tr.count), 64'd0);
        chk("flush.en", 64'(tr.check_en), 64'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom % 2), $urandom, 1'($urandom % 2),
                  2'($urandom % 4), $urandom, $urandom,
                  1'($urandom % 3 != 0), 1'($urandom % 64 == 0));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
